alu_scheduler: RTL and testbench
================================

# alu_scheduler

Shares the single `ALU` instance in the EX stage between two requesters: port 0 is the pipeline execute path and port 1 is the auxiliary address/immediate path. It arbitrates round-robin, registers the operands and drives the ALU inputs, then captures the result. The result is held on a response channel with valid/ready backpressure. Optionally, it sequences a multi-cycle shift-add multiply through the ALU adder. The ALU itself stays outside the block and connects through the `alu_*` ports.

## Interface
- `W`, default `` `WORD_SIZE `` (16): datapath width.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous active-low reset.
- `req0_valid`, `req1_valid` in 1: request valid.
- `req0_ready`, `req1_ready` out 1: request accepted when valid&ready at a clock edge.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in W: operands.
- `req0_func`, `req1_func` in 4: ALU function code.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: port that issued the response.
- `rsp_data` out W: result.
- `rsp_err` out 1: function code was rejected.
- `alu_a`, `alu_b` out W; `alu_func` out 4; `alu_c` in W: connection to the ALU.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - `req_ready` is high only toward the granted port, and only when that port is valid.
  - If both ports are valid, grant the port not granted last (`last_grant`).
  - If one port is valid, that port wins.
  - Accept: latch a, b, func and id.
  - Legal func (0000–1010) → EXEC.
  - 1111 → MUL if `ALU_SCHED_MUL_EN` is defined, otherwise treated as illegal.
  - 1011–1110 (and 1111 without the macro) → RESP with `rsp_err`=1 and `rsp_data`=0.
- EXEC: `alu_a`/`alu_b`/`alu_func` come from the latched registers. At the clock edge, `rsp_data` ← `alu_c` and state → RESP.
- MUL: each iteration drives `alu_a`=acc, `alu_b`=mcand, `alu_func`=0000.
  - If `mplier[0]`, acc ← `alu_c`.
  - mcand ← mcand<<1 and mplier ← mplier>>1.
  - Runs exactly W iterations on a counter, with no early exit.
  - Result is acc mod 2^W, then → RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_id` and `rsp_err` stay stable until `rsp_ready`.
  - On `rsp_ready`, → IDLE. A new request is not accepted in that same cycle.
- `last_grant` updates only on accept.
- ALU inputs are 0/0/0000 whenever the state is not EXEC or MUL.

## Timing
- Reset values: IDLE; `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0; `busy`=0; `last_grant`=1, so port 0 wins first; all internal registers are 0.
- Latency is counted from an accept at edge N:
  - Legal op: EXEC in cycle N+1, `rsp_valid` from cycle N+2.
  - MUL: cycles N+1..N+W, `rsp_valid` from cycle N+W+1.
  - Illegal op: `rsp_valid` from cycle N+1.
- Throughput: at best one legal op every 3 cycles.
- `req_ready` is combinational from the state, `reqX_valid` and `last_grant`. A requester must not wait for ready before raising valid.
- `reset_n` low at an edge in any state returns to IDLE with reset values. An in-flight op and any pending response are dropped.
- With `rsp_ready` held high, RESP lasts exactly one cycle.

## Configuration
- `ALU_SCHED_MUL_EN` defined: func 1111 runs the W-cycle shift-add multiply. The MUL state, acc/mcand/mplier registers and iteration counter are compiled in.
- Not defined: MUL logic is absent and 1111 returns `rsp_err`=1, `rsp_data`=0.

## Structure
- Add to `parameter.v`:
  - ALU function `define`s (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_ORR`, `ALU_NOT`, `ALU_TCP`, `ALU_SHL`, `ALU_SHR`, `ALU_ADI`, `ALU_ORI`, `ALU_LHI`, `ALU_MUL`=4'b1111).
  - The scheduler state encodings.
- Sub-module `rr_arbiter2`: a combinational 2-port round-robin picker. Inputs: valid[1:0], last_grant. Outputs: grant one-hot, grant_id.

## Test plan
- Single op: after reset, port 0 sends add 0x0003+0x0004 (func 0000) → accept, then `rsp_valid` 2 cycles later with `rsp_data`=0x0007, `rsp_id`=0, `rsp_err`=0.
- Contention: both ports valid after reset. Port 0 sends sub 0x0010−0x0001; port 1 sends LHI (func 1010) with b=0x0012.
  - Port 0 is served first → 0x000F.
  - Port 1 is served next → 0x1200, `rsp_id`=1.
- Backpressure: `rsp_ready` held low for 5 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay stable, both `req_ready`=0 and `busy`=1. The response completes on the first `rsp_ready`.
- Illegal func 1100 → `rsp_valid` the cycle after accept, with `rsp_err`=1 and `rsp_data`=0x0000. No ALU activity occurs (`alu_func`=0000).
- Multiply, func 1111 on 0x0012×0x0034:
  - With `ALU_SCHED_MUL_EN`: `rsp_data`=0x03A8, `rsp_valid` 17 cycles after accept.
  - Without the macro: `rsp_err`=1, `rsp_data`=0.
- Reset mid-EXEC (and mid-MUL): `reset_n` low for one edge → the next cycle shows `rsp_valid`=0 and `busy`=0. With both ports valid, the next grant goes to port 0.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// rtl/alu_scheduler_pkg.sv - shared constants for the two-port ALU scheduler
//
// Purpose : ALU function codes, scheduler state encodings and the opcode
//           classifier used by alu_scheduler.
// Contents: ALU_* function codes (ALU_MUL = 4'b1111), ST_* state encodings,
//           op_class_t and classify().
// Config  : ALU_SCHED_MUL_EN - when defined, ALU_MUL classifies as a multiply;
//           otherwise it is rejected like any other unknown code.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package alu_scheduler_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_TCP = 4'b0101;
  localparam logic [3:0] ALU_SHL = 4'b0110;
  localparam logic [3:0] ALU_SHR = 4'b0111;
  localparam logic [3:0] ALU_ADI = 4'b1000;
  localparam logic [3:0] ALU_ORI = 4'b1001;
  localparam logic [3:0] ALU_LHI = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    OPC_ALU = 2'd0,
    OPC_MUL = 2'd1,
    OPC_ILL = 2'd2
  } op_class_t;

  // Every code up to LHI goes straight to the ALU; the multiply code is only
  // recognised when the sequencer is built in.
  function automatic op_class_t classify(input logic [3:0] func);
    op_class_t cls;
    cls = OPC_ILL;
    if (func <= ALU_LHI) begin
      cls = OPC_ALU;
    end
`ifdef ALU_SCHED_MUL_EN
    else if (func == ALU_MUL) begin
      cls = OPC_MUL;
    end
`endif
    return cls;
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// rtl/alu_scheduler_rr_arbiter2.sv - combinational two-port round-robin picker
//
// Purpose : Chooses which requester owns the ALU this cycle.
// Ports   : valid[1:0]  in  - per-port request valid
//           last_grant  in  - port granted on the previous accept
//           grant[1:0]  out - one-hot grant, zero when nobody is valid
//           grant_id    out - index of the granted port
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      // Under contention the port that did not win last time goes first.
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
    if (valid != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - shares one external ALU between two requesters
//
// Purpose : Round-robin arbitration between the execute path (port 0) and the
//           auxiliary address/immediate path (port 1). Operands are latched,
//           driven onto the ALU for one cycle, and the result is held on a
//           valid/ready response channel.
// Ports   : clk, reset_n (synchronous, active low)
//           req{0,1}_valid/ready/a/b/func - request channels
//           rsp_valid/ready/id/data/err   - response channel
//           alu_a/alu_b/alu_func out, alu_c in - external ALU connection
//           busy                          - state is not IDLE
// Config  : ALU_SCHED_MUL_EN - builds the W-cycle shift-add multiply (func
//           4'b1111) that iterates through the ALU adder; without it that
//           code is answered with rsp_err=1, rsp_data=0.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int W = `WORD_SIZE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_func,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_func,
  input  logic [W-1:0] alu_c,
  output logic         busy
);

  logic [1:0]   state;
  logic         last_grant;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [3:0]   func_q;
  logic         id_q;
  logic [W-1:0] data_q;
  logic         err_q;

  logic [1:0]   grant;
  logic         grant_id;
  logic         accept;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [3:0]   sel_func;

`ifdef ALU_SCHED_MUL_EN
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
`endif

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Ready is only offered from IDLE, so a request can never be taken in the
  // same cycle the previous response retires.
  assign req0_ready = (state == ST_IDLE) & grant[0];
  assign req1_ready = (state == ST_IDLE) & grant[1];
  assign accept     = req0_ready | req1_ready;

  assign sel_a    = grant_id ? req1_a    : req0_a;
  assign sel_b    = grant_id ? req1_b    : req0_b;
  assign sel_func = grant_id ? req1_func : req0_func;

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state != ST_IDLE);

  // The ALU sees zeros except while an op is actually using it, so idle and
  // response cycles cause no switching on the shared datapath.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_func = ALU_ADD;
    case (state)
      ST_EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_func = func_q;
      end
`ifdef ALU_SCHED_MUL_EN
      ST_MUL: begin
        alu_a    = acc;
        alu_b    = mcand;
        alu_func = ALU_ADD;
      end
`endif
      default: begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= '0;
      id_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            func_q     <= sel_func;
            id_q       <= grant_id;
            last_grant <= grant_id;
            err_q      <= 1'b0;
            case (classify(sel_func))
              OPC_ALU: state <= ST_EXEC;
`ifdef ALU_SCHED_MUL_EN
              OPC_MUL: begin
                acc    <= '0;
                mcand  <= sel_a;
                mplier <= sel_b;
                cnt    <= '0;
                state  <= ST_MUL;
              end
`endif
              default: begin
                // Rejected codes answer immediately without touching the ALU.
                data_q <= '0;
                err_q  <= 1'b1;
                state  <= ST_RESP;
              end
            endcase
          end
        end
        ST_EXEC: begin
          data_q <= alu_c;
          state  <= ST_RESP;
        end
`ifdef ALU_SCHED_MUL_EN
        ST_MUL: begin
          // One multiplier bit per cycle; the adder result is only kept when
          // that bit is set. Always W iterations so latency is fixed.
          if (mplier[0]) begin
            acc <= alu_c;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            data_q <= mplier[0] ? alu_c : acc;
            state  <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - scoreboard bench for alu_scheduler
module tb_alu_scheduler;

  localparam int W = 16;

`ifdef ALU_SCHED_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_c;
  logic [3:0]   alu_func;

  logic         pv [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic [3:0]   pf [2];
  logic         acc_flag [2];

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         err;
    int           first_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_scheduler #(.W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (pv[0]),
    .req0_ready (req0_ready),
    .req0_a     (pa[0]),
    .req0_b     (pb[0]),
    .req0_func  (pf[0]),
    .req1_valid (pv[1]),
    .req1_ready (req1_ready),
    .req1_a     (pa[1]),
    .req1_b     (pb[1]),
    .req1_func  (pf[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_c      (alu_c),
    .busy       (busy)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~a;
      4'd5:    return -a;
      4'd6:    return a << 1;
      4'd7:    return a >> 1;
      4'd8:    return a + b;
      4'd9:    return a | b;
      4'd10:   return {b[7:0], 8'h00};
      default: return '0;
    endcase
  endfunction

  always_comb alu_c = alu_fn(alu_a, alu_b, alu_func);

  // Expected response for an op accepted at edge n.
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] f, input int n);
    exp_t e;
    logic [2*W-1:0] prod;
    e.id = id;
    e.err = 1'b0;
    e.data = '0;
    e.first_cyc = n + 1;
    if (f <= 4'd10) begin
      e.data = alu_fn(a, b, f);
      e.first_cyc = n + 2;
    end else if (f == 4'hF && MUL_EN) begin
      prod = a * b;
      e.data = prod[W-1:0];
      e.first_cyc = n + W + 1;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic rdy_of(input int i);
    return (i == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic retire();
    for (int i = 0; i < 2; i++) begin
      if (acc_flag[i]) begin
        pv[i] = 1'b0;
        acc_flag[i] = 1'b0;
      end
    end
  endtask

  // Called at negedge after inputs are set: a valid port seeing ready now is
  // taken at the coming edge, numbered cyc+1.
  task automatic evaluate();
    logic id;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pv[i] && rdy_of(i)) begin
        id = (i == 1);
        acc_flag[i] = 1'b1;
        exp_q.push_back(model(id, pa[i], pb[i], pf[i], cyc + 1));
      end
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f);
    pv[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
    pf[i] = f;
  endtask

  task automatic drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      retire();
      evaluate();
      if (!pv[0] && !pv[1] && exp_q.size() == 0 && !rsp_valid && !busy) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0;
      acc_flag[i] = 1'b0;
    end
  endtask

  // Monitor: runs late in each low phase, after stimulus has settled.
  initial begin
    logic         prev_valid;
    logic         stall_v;
    logic         stall_id;
    logic         stall_e;
    logic [W-1:0] stall_d;
    exp_t         e;
    prev_valid = 1'b0;
    stall_v = 1'b0;
    stall_id = 1'b0;
    stall_e = 1'b0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n !== 1'b1) begin
        prev_valid = 1'b0;
        stall_v = 1'b0;
      end else begin
        if (!busy || rsp_valid) check("alu_quiet", {alu_a, alu_b, alu_func}, 0);
        if (rsp_valid) check("req_ready_in_resp", {req0_ready, req1_ready}, 0);
        if (stall_v) begin
          check("hold_valid", rsp_valid, 1'b1);
          check("hold_data", rsp_data, stall_d);
          check("hold_id", rsp_id, stall_id);
          check("hold_err", rsp_err, stall_e);
        end
        if (rsp_valid && !prev_valid) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
          else check("rsp_latency", cyc + 1, exp_q[0].first_cyc);
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
        end
        stall_v = rsp_valid && !rsp_ready;
        stall_d = rsp_data;
        stall_id = rsp_id;
        stall_e = rsp_err;
        prev_valid = rsp_valid;
      end
    end
  end

  initial begin
    logic seen;
    int   r;
    reset_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
      pf[i] = '0;
      acc_flag[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id_err", {rsp_id, rsp_err}, 0);
    check("reset_alu", {alu_a, alu_b, alu_func}, 0);
    reset_n = 1'b1;

    // Contention straight out of reset: port 0 first, then port 1.
    set_req(0, 16'h0010, 16'h0001, 4'b0001);
    set_req(1, 16'h5555, 16'h0012, 4'b1010);
    evaluate();
    check("first_grant_port0", {req1_ready, req0_ready}, 2'b01);
    drain("contention_drain", 40);

    // Single add.
    @(negedge clk);
    set_req(0, 16'h0003, 16'h0004, 4'b0000);
    evaluate();
    drain("single_drain", 20);

    // Backpressure with port 1 waiting behind the held response.
    rsp_ready = 1'b0;
    @(negedge clk);
    set_req(0, 16'h1234, 16'h00FF, 4'b0010);
    evaluate();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      retire();
      evaluate();
      seen = rsp_valid;
    end
    check("bp_rsp_seen", seen, 1'b1);
    set_req(1, 16'h00A0, 16'h000B, 4'b1000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      retire();
      evaluate();
      check("bp_busy", busy, 1'b1);
      check("bp_req_ready", {req1_ready, req0_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    drain("bp_drain", 40);

    // Rejected code, then multiply.
    @(negedge clk);
    set_req(0, 16'h7777, 16'h8888, 4'b1100);
    evaluate();
    drain("illegal_drain", 20);
    @(negedge clk);
    set_req(1, 16'h0012, 16'h0034, 4'b1111);
    evaluate();
    drain("mul_drain", 60);

    // Reset in the middle of an EXEC and of a multiply.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      set_req(1, 16'h0101, 16'h0202, (t == 0) ? 4'b0000 : 4'b1111);
      evaluate();
      @(negedge clk);
      retire();
      if (t == 1 && MUL_EN) repeat (4) @(negedge clk);
      check("pre_reset_busy", busy, 1'b1);
      do_reset();
      @(negedge clk);
      check("post_reset_rsp_valid", rsp_valid, 1'b0);
      check("post_reset_busy", busy, 1'b0);
      reset_n = 1'b1;
      set_req(0, 16'h0F0F, 16'h0101, 4'b0011);
      set_req(1, 16'h1111, 16'h2222, 4'b0001);
      evaluate();
      check("post_reset_grant", {req1_ready, req0_ready}, 2'b01);
      drain("post_reset_drain", 40);
    end

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      retire();
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 9);
          set_req(i, W'($urandom), W'($urandom),
                  (r < 7) ? 4'($urandom_range(0, 10)) :
                  (r < 9) ? 4'hF : 4'($urandom_range(11, 14)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      evaluate();
    end
    rsp_ready = 1'b1;
    drain("final_drain", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
